// File: rtl/scsp_timer_irq_if.sv
// Bundle of SCSP timer/interrupt signals; master drives controls, slave returns counters, pending and level.
// Purely combinational wiring; no handshake, all strobes are single-cycle.
interface scsp_timer_irq_if #(
  parameter int NUM_TIMERS = 3,
  parameter int CNT_W      = 8,
  parameter int NUM_SRC    = 11
);
  logic                        smpl_ce;
  logic [NUM_TIMERS-1:0]       tim_wr;
  logic [CNT_W+2:0]            tim_data;
  logic [NUM_TIMERS*CNT_W-1:0] tim_cnt;
  logic [NUM_SRC-1:0]          ext_ev;
  logic [NUM_SRC-1:0]          ieb;
  logic                        set_wr;
  logic                        clr_wr;
  logic [NUM_SRC-1:0]          set_data;
  logic [NUM_SRC-1:0]          clr_data;
  logic [NUM_SRC-1:0]          lv0;
  logic [NUM_SRC-1:0]          lv1;
  logic [NUM_SRC-1:0]          lv2;
  logic [NUM_SRC-1:0]          pend;
  logic [2:0]                  irq_lvl;

  modport master (
    output smpl_ce, tim_wr, tim_data, ext_ev, ieb, set_wr, clr_wr,
           set_data, clr_data, lv0, lv1, lv2,
    input  tim_cnt, pend, irq_lvl
  );

  modport slave (
    input  smpl_ce, tim_wr, tim_data, ext_ev, ieb, set_wr, clr_wr,
           set_data, clr_data, lv0, lv1, lv2,
    output tim_cnt, pend, irq_lvl
  );
endinterface

// File: rtl/scsp_timer_irq.sv
// SCSP sample-rate timers with prescale, interrupt-pending register and registered 3-bit priority level.
// Latency: writes/events reach PEND in 1 clock and IRQ_LVL in 2; no backpressure, inputs always accepted.
module scsp_timer_irq #(
  parameter int NUM_TIMERS     = 3,
  parameter int CNT_W          = 8,
  parameter int NUM_SRC        = 11,
  parameter int TIMER_SRC_BASE = 6,
  parameter int AUTO_RELOAD    = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  scsp_timer_irq_if.slave bus
);

  logic [6:0]                  ps_q, ps_d;
  logic [NUM_TIMERS-1:0]       tick;
  logic [NUM_TIMERS-1:0]       ovf;
  logic [NUM_TIMERS*CNT_W-1:0] cnt_flat;
  logic [NUM_SRC-1:0]          pend_q, pend_d;
  logic [NUM_SRC-1:0]          tmr_set, tmr_pos, sets, act;
  logic [2:0]                  irq_q, irq_d;

  assign ps_d = bus.smpl_ce ? ps_q + 7'd1 : ps_q;

  genvar g;
  for (g = 0; g < NUM_TIMERS; g++) begin : g_tmr
    logic [CNT_W-1:0] cnt_q, cnt_d, reload_q, reload_d;
    logic [2:0]       tctl_q, tctl_d;
    logic [6:0]       ps_mask;
    logic             ovf_l;

    // Tick when the low TCTL bits of the pre-increment prescaler are all ones.
    assign ps_mask       = 7'((8'd1 << tctl_q) - 8'd1);
    assign tick[g]       = bus.smpl_ce & ((ps_q & ps_mask) == ps_mask);
    assign ovf[g]        = ovf_l;
    assign cnt_flat[g*CNT_W +: CNT_W] = cnt_q;

    always_comb begin
      cnt_d    = cnt_q;
      reload_d = reload_q;
      tctl_d   = tctl_q;
      ovf_l    = 1'b0;
      if (bus.tim_wr[g]) begin
        cnt_d    = bus.tim_data[CNT_W-1:0];
        reload_d = bus.tim_data[CNT_W-1:0];
        tctl_d   = bus.tim_data[CNT_W +: 3];
      end else if (tick[g]) begin
        if (&cnt_q) begin
          cnt_d = (AUTO_RELOAD != 0) ? reload_q : '0;
          ovf_l = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q    <= '0;
        reload_q <= '0;
        tctl_q   <= '0;
      end else begin
        cnt_q    <= cnt_d;
        reload_q <= reload_d;
        tctl_q   <= tctl_d;
      end
    end
  end

  always_comb begin
    tmr_set = '0;
    tmr_pos = '0;
    for (int t = 0; t < NUM_TIMERS; t++) begin
      tmr_set[TIMER_SRC_BASE+t] = ovf[t];
      tmr_pos[TIMER_SRC_BASE+t] = 1'b1;
    end
  end

  // Sets are OR-ed in after the clear so a same-cycle set wins.
  assign sets   = tmr_set | (bus.ext_ev & ~tmr_pos) | (bus.set_wr ? bus.set_data : '0);
  assign pend_d = (pend_q & ~(bus.clr_wr ? bus.clr_data : '0)) | sets;
  assign act    = pend_q & bus.ieb;

  always_comb begin
    irq_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (act[i] && ({bus.lv2[i], bus.lv1[i], bus.lv0[i]} > irq_d)) begin
        irq_d = {bus.lv2[i], bus.lv1[i], bus.lv0[i]};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ps_q   <= '0;
      pend_q <= '0;
      irq_q  <= '0;
    end else begin
      ps_q   <= ps_d;
      pend_q <= pend_d;
      irq_q  <= irq_d;
    end
  end

  assign bus.tim_cnt = cnt_flat;
  assign bus.pend    = pend_q;
  assign bus.irq_lvl = irq_q;

endmodule

// File: tb/tb_scsp_timer_irq.sv
// Directed bench for scsp_timer_irq: wrap-to-zero instance plus an auto-reload instance,
// expectations queued on drive and compared one clock edge later.
module tb_scsp_timer_irq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  scsp_timer_irq_if #(.NUM_TIMERS(3), .CNT_W(8), .NUM_SRC(11)) b1 ();
  scsp_timer_irq_if #(.NUM_TIMERS(3), .CNT_W(8), .NUM_SRC(11)) b2 ();

  scsp_timer_irq #(.NUM_TIMERS(3), .CNT_W(8), .NUM_SRC(11), .TIMER_SRC_BASE(6), .AUTO_RELOAD(0))
    u_dut (.clk_i(clk), .rst_ni(rst_n), .bus(b1.slave));
  scsp_timer_irq #(.NUM_TIMERS(3), .CNT_W(8), .NUM_SRC(11), .TIMER_SRC_BASE(6), .AUTO_RELOAD(1))
    u_dut_ar (.clk_i(clk), .rst_ni(rst_n), .bus(b2.slave));

  int          tests = 0;
  int          fails = 0;
  int          kind_q[$];
  logic [31:0] val_q[$];
  string       tag_q[$];

  function automatic logic [31:0] observe(input int k);
    case (k)
      0:       return 32'(b1.pend);
      1:       return 32'(b1.irq_lvl);
      2:       return 32'(b1.tim_cnt[7:0]);
      3:       return 32'(b1.tim_cnt[15:8]);
      4:       return 32'(b1.tim_cnt);
      5:       return 32'(b2.tim_cnt[7:0]);
      6:       return 32'(b2.pend);
      default: return 32'(b2.irq_lvl);
    endcase
  endfunction

  task automatic exp_push(input int k, input logic [31:0] v, input string tag);
    kind_q.push_back(k);
    val_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check();
    int          k;
    logic [31:0] e, o;
    string       t;
    while (kind_q.size() > 0) begin
      k = kind_q.pop_front();
      e = val_q.pop_front();
      t = tag_q.pop_front();
      o = observe(k);
      tests++;
      assert (o === e) else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", t, o, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    b1.tim_wr = '0; b1.set_wr = 1'b0; b1.clr_wr = 1'b0; b1.ext_ev = '0;
    b2.tim_wr = '0; b2.clr_wr = 1'b0;
  endtask

  task automatic idle_bus();
    b1.smpl_ce = 1'b0; b1.tim_wr = '0; b1.tim_data = '0; b1.ext_ev = '0; b1.ieb = '0;
    b1.set_wr = 1'b0; b1.clr_wr = 1'b0; b1.set_data = '0; b1.clr_data = '0;
    b2.smpl_ce = 1'b0; b2.tim_wr = '0; b2.tim_data = '0; b2.ext_ev = '0; b2.ieb = '0;
    b2.set_wr = 1'b0; b2.clr_wr = 1'b0; b2.set_data = '0; b2.clr_data = '0;
    // level(1)=3, level(2)=2, level(6)=5, level(7)=4, level(9)=6, others 0
    b1.lv0 = 11'h042; b1.lv1 = 11'h206; b1.lv2 = 11'h2C0;
    b2.lv0 = 11'h042; b2.lv1 = 11'h206; b2.lv2 = 11'h2C0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    idle_bus();
    #2 rst_n = 1'b0;
    #1;
    exp_push(0, 32'h0, "reset_pend");
    exp_push(1, 32'h0, "reset_irq");
    exp_push(4, 32'h0, "reset_cnt");
    exp_push(6, 32'h0, "reset_pend_ar");
    check();
    @(negedge clk) rst_n = 1'b1;

    // Auto-reload instance: wrap returns to the load value.
    b2.tim_wr = 3'b001; b2.tim_data = {3'd0, 8'hFD};
    step(); exp_push(5, 32'hFD, "ar_load"); check();
    b2.smpl_ce = 1'b1;
    step(); exp_push(5, 32'hFE, "ar_tick1"); check();
    step(); exp_push(5, 32'hFF, "ar_tick2"); exp_push(6, 32'h0, "ar_pend_pre"); check();
    step(); exp_push(5, 32'hFD, "ar_wrap1"); exp_push(6, 32'h040, "ar_ovf1"); check();
    b2.smpl_ce = 1'b0; b2.clr_wr = 1'b1; b2.clr_data = 11'h040;
    step(); exp_push(6, 32'h0, "ar_clr"); check();
    b2.smpl_ce = 1'b1;
    step(); exp_push(5, 32'hFE, "ar_tick4"); check();
    step(); exp_push(6, 32'h0, "ar_pend_pre2"); check();
    step(); exp_push(5, 32'hFD, "ar_wrap2"); exp_push(6, 32'h040, "ar_ovf2"); check();
    b2.smpl_ce = 1'b0;

    // Timer 0 wrap, pending and level.
    b1.ieb = 11'h040;
    b1.tim_wr = 3'b001; b1.tim_data = {3'd0, 8'hFE};
    step(); exp_push(2, 32'hFE, "t0_load"); check();
    b1.smpl_ce = 1'b1;
    step(); exp_push(2, 32'hFF, "t0_tick1"); exp_push(0, 32'h0, "t0_pend_pre"); check();
    step(); exp_push(2, 32'h00, "t0_wrap"); exp_push(0, 32'h040, "t0_ovf");
    exp_push(1, 32'h0, "t0_irq_lag"); check();
    b1.smpl_ce = 1'b0;
    step(); exp_push(1, 32'h5, "t0_irq"); check();
    b1.clr_wr = 1'b1; b1.clr_data = 11'h040;
    step(); exp_push(0, 32'h0, "t0_clr"); exp_push(1, 32'h5, "t0_irq_hold"); check();
    step(); exp_push(1, 32'h0, "t0_irq_drop"); check();

    // Prescale 3 from a fresh PS: overflow on exactly the 8th sample.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    b1.tim_wr = 3'b010; b1.tim_data = {3'd3, 8'hFF};
    step(); exp_push(3, 32'hFF, "t1_load"); check();
    b1.smpl_ce = 1'b1;
    repeat (7) step();
    exp_push(3, 32'hFF, "t1_hold7"); exp_push(0, 32'h0, "t1_pend7"); check();
    step(); exp_push(3, 32'h00, "t1_wrap8"); exp_push(0, 32'h080, "t1_ovf8");
    exp_push(2, 32'h08, "t0_ps0_count"); check();
    b1.smpl_ce = 1'b0;

    // External event versus clear; timer-position event ignored.
    b1.ieb = 11'h004;
    b1.ext_ev = 11'h004; b1.clr_wr = 1'b1; b1.clr_data = 11'h084;
    step(); exp_push(0, 32'h004, "ev_set_beats_clr"); check();
    b1.clr_wr = 1'b1; b1.clr_data = 11'h004;
    step(); exp_push(0, 32'h0, "ev_clr"); exp_push(1, 32'h2, "ev_irq_hold"); check();
    step(); exp_push(1, 32'h0, "ev_irq_drop"); check();
    b1.ext_ev = 11'h040;
    step(); exp_push(0, 32'h0, "ev_timer_pos_ignored"); check();

    // Priority reduction and enable mask.
    b1.ieb = 11'h202; b1.set_wr = 1'b1; b1.set_data = 11'h202;
    step(); exp_push(0, 32'h202, "sw_set"); check();
    step(); exp_push(1, 32'h6, "prio_max"); check();
    b1.ieb = 11'h002;
    step(); exp_push(1, 32'h3, "prio_masked"); exp_push(0, 32'h202, "pend_unmasked"); check();
    b1.ieb = 11'h001; b1.clr_wr = 1'b1; b1.clr_data = 11'h202;
    b1.set_wr = 1'b1; b1.set_data = 11'h001;
    step(); exp_push(0, 32'h001, "lvl0_pend"); check();
    step(); exp_push(1, 32'h0, "lvl0_no_irq"); check();
    b1.clr_wr = 1'b1; b1.clr_data = 11'h001;
    step();

    // Write coincident with the overflowing tick.
    b1.tim_wr = 3'b001; b1.tim_data = {3'd0, 8'hFF};
    step(); exp_push(2, 32'hFF, "wr_pre"); check();
    b1.smpl_ce = 1'b1; b1.tim_wr = 3'b001; b1.tim_data = {3'd0, 8'h12};
    step(); exp_push(2, 32'h12, "wr_beats_tick"); exp_push(0, 32'h0, "wr_no_ovf"); check();
    step(); exp_push(2, 32'h13, "tick_after_wr"); check();
    b1.smpl_ce = 1'b0;

    // Asynchronous reset mid-count.
    b1.ieb = 11'h002; b1.set_wr = 1'b1; b1.set_data = 11'h002;
    step(); step(); exp_push(1, 32'h3, "pre_rst_irq"); check();
    #2 rst_n = 1'b0;
    #1;
    exp_push(0, 32'h0, "arst_pend"); exp_push(1, 32'h0, "arst_irq");
    exp_push(4, 32'h0, "arst_cnt"); check();
    #2 rst_n = 1'b1;
    b1.smpl_ce = 1'b1;
    step(); exp_push(4, 32'h010101, "first_ce_all_tick"); check();
    b1.smpl_ce = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scsp_timer_irq.md
# scsp_timer_irq

Parametrised timer and interrupt-priority block for the SCSP sound core. It holds NUM_TIMERS sample-rate timers, each with a per-timer prescale select. Timer overflows and external event pulses set an interrupt-pending register. Pending, enabled sources are reduced to a registered 3-bit interrupt level for the sound CPU, with optional auto-reload on top of the classic 3-timer, 11-source arrangement.

## Interface
Parameters:
- NUM_TIMERS, 3 — number of timers (A/B/C at default).
- CNT_W, 8 — timer counter width.
- NUM_SRC, 11 — number of interrupt sources.
- TIMER_SRC_BASE, 6 — pending bit of timer 0; timer t maps to bit TIMER_SRC_BASE+t. Must satisfy TIMER_SRC_BASE+NUM_TIMERS ≤ NUM_SRC.
- AUTO_RELOAD, 0 — 0: counter wraps to 0; 1: counter wraps to last written load value.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset; one clock; reset is asynchronous and active-low.
- SMPL_CE  in  1  one-cycle pulse per output sample.
- TIM_WR  in  NUM_TIMERS  per-timer write strobe.
- TIM_DATA  in  3+CNT_W  {TCTL[2:0], load value}.
- TIM_CNT  out  NUM_TIMERS*CNT_W  current counters, timer 0 in LSBs.
- EXT_EV  in  NUM_SRC  external event pulses; bits at timer positions are ignored.
- IEB  in  NUM_SRC  interrupt enable mask.
- SET_WR  in  1  software set of pending: OR PEND with SET_DATA.
- CLR_WR  in  1  write-1-to-clear of pending using CLR_DATA.
- SET_DATA, CLR_DATA  in  NUM_SRC  masks.
- LV0, LV1, LV2  in  NUM_SRC  per-source level bits; level(i) = {LV2[i],LV1[i],LV0[i]}.
- PEND  out  NUM_SRC  pending register.
- IRQ_LVL  out  3  highest level among PEND & IEB; 0 = no request.

## Operation
- Prescaler: one shared, free-running 7-bit counter PS, incremented on each SMPL_CE and wrapping 127→0.
- Timer tick: on SMPL_CE, timer t ticks when PS[TCTL_t-1:0] is all ones, evaluated on the pre-increment PS. TCTL=0 ticks every sample; TCTL=n ticks every 2^n samples.
- On tick, CNT increments. At all-ones→wrap, CNT loads 0 (AUTO_RELOAD=0) or RELOAD_t (AUTO_RELOAD=1), and the overflow event sets PEND[TIMER_SRC_BASE+t].
- TIM_WR[t]: CNT_t, RELOAD_t and TCTL_t load from TIM_DATA. A write takes precedence over a coincident tick; that tick is lost and raises no overflow. The write does not touch PS.
- PEND next value = (PEND & ~(CLR_WR ? CLR_DATA : 0)) | sets.
  - Sets = timer overflows | external events | (SET_WR ? SET_DATA : 0).
  - Set beats clear on the same bit in the same cycle.
- Level reduction:
  - A = PEND & IEB.
  - IRQ_LVL register ← max of level(i) over set bits of A, or 0 if A is zero.
  - A source with level 0 pending contributes nothing.
- Changing IEB or LVx affects IRQ_LVL on the next clock only; PEND itself is never masked.

## Timing
- Reset values: PS=0, every CNT/RELOAD/TCTL=0, PEND=0, IRQ_LVL=0, TIM_CNT=0.
- Reset asserted mid-count clears all state immediately (asynchronous). The first SMPL_CE after release sees PS=0, so every timer ticks on it.
- Timer write: TIM_CNT shows the new value after 1 clock.
- Overflow: the PEND bit is set at the clock edge that samples the wrapping SMPL_CE. IRQ_LVL reflects it 1 clock later, so event-to-level latency is 2 clocks.
- EXT_EV, SET_WR and CLR_WR each take effect on PEND in 1 clock, and on IRQ_LVL in 2 clocks.
- No SMPL_CE means counters and PS hold; there is no other clock gating.

## Test plan
- Reset, then CNT_W=8, TCTL=0, load 0xFE on timer 0, 2 SMPL_CE → CNT 0xFF then 0x00; PEND[6]=1 on the 2nd edge.
  - With IEB[6]=1 and level(6)=5: IRQ_LVL=5 one clock later.
- TCTL=3 on timer 1, load 0xFF → exactly 8 SMPL_CE pulses to the overflow; PEND[7] sets after the 8th.
- AUTO_RELOAD=1, load 0xFD → wrap gives CNT=0xFD; a 2nd overflow follows 3 ticks later.
- Same-cycle EXT_EV[2] and CLR_WR with CLR_DATA[2]=1 → PEND[2]=1. A clear alone next cycle → PEND[2]=0, and IRQ_LVL returns to 0 two clocks after the clear.
- PEND bits 1 (level 3) and 9 (level 6), both enabled → IRQ_LVL=6. Clear IEB[9] → IRQ_LVL=3 next clock.
- TIM_WR coincident with the overflowing tick → counter takes the written value and PEND is unchanged. Assert RST_N low mid-count → all outputs 0 without waiting for a clock edge.
